// File: rtl/mcu_spi_host.sv
`default_nettype none
// ============================================================================
// Module   : mcu_spi_host
// Purpose  : Byte-oriented SPI mode-0 master for the FPGA Companion link.
//            It drives sclk/csn/mosi toward a core's MCU-side SPI slave and
//            samples miso. Transmit uses a valid/ready handshake, and receive
//            is a one-cycle strobe. Frames close on tx_last or on frame_end.
// Options  : define MCU_SPI_HOST_IRQ_EN to synchronise mcu_intn onto irq.
// Revision : 1.0 - initial release
// ============================================================================
module mcu_spi_host #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    input  logic       frame_end,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       irq,
    output logic       mcu_sclk,
    output logic       mcu_csn,
    output logic       mcu_mosi,
    input  logic       mcu_miso,
    input  logic       mcu_intn
);

    localparam logic [7:0] c_half_reload = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_WAIT  = 3'd3,
        S_HOLD  = 3'd4,
        S_DESEL = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_half_cnt;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_tx_shift;     // bits still to be driven after the current one
    logic [7:0] r_rx_shift;
    logic       r_last;
    logic       r_sclk;
    logic       r_csn;
    logic       r_mosi;
    logic       r_rx_valid;
    logic [7:0] r_rx_data;

    logic       w_tx_ready;
    logic       w_accept;
    logic       w_half_done;
    logic       w_rise;
    logic       w_fall;
    logic       w_last_fall;
    logic       w_enter;

    assign w_half_done = (r_half_cnt == 8'd0);
    assign w_last_fall = w_fall & (r_bit_cnt == 3'd7);
    assign w_enter     = (w_state_nxt != r_state);

    // Next-state decode plus the sclk edge strobes that steer the datapath
    always_comb begin
        w_state_nxt = r_state;
        w_tx_ready  = 1'b0;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_ready = 1'b1;
            end
            S_SETUP: begin
                if (w_half_done) begin
                    w_state_nxt = S_SHIFT;
                    w_rise      = 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_half_done) begin
                    if (r_sclk) begin
                        w_fall = 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = r_last ? S_HOLD : S_WAIT;
                        end
                    end else begin
                        w_rise = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // frame_end wins over a byte offered in the same cycle
                w_tx_ready = ~frame_end;
                if (frame_end) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_half_done) begin
                    w_state_nxt = S_DESEL;
                end
            end
            S_DESEL: begin
                if (w_half_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_tx_ready = w_tx_ready & ~reset;
        w_accept   = tx_valid & w_tx_ready;
        if (w_accept) begin
            w_state_nxt = S_SETUP;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Half-period and bit counters; both restart on every state entry
    always_ff @(posedge clk) begin
        if (reset) begin
            r_half_cnt <= c_half_reload;
            r_bit_cnt  <= 3'd0;
        end else if (w_enter) begin
            r_half_cnt <= c_half_reload;
            r_bit_cnt  <= 3'd0;
        end else if ((r_state == S_SHIFT) && w_half_done) begin
            r_half_cnt <= c_half_reload;
            if (w_fall) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end else if (!w_half_done) begin
            r_half_cnt <= r_half_cnt - 8'd1;
        end
    end

    // Pin drivers and shift registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk     <= 1'b0;
            r_csn      <= 1'b1;
            r_mosi     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= 8'h00;
            r_tx_shift <= 7'd0;
            r_rx_shift <= 8'h00;
            r_last     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_accept) begin
                r_tx_shift <= tx_data[6:0];
                r_last     <= tx_last;
                r_csn      <= 1'b0;
                r_mosi     <= tx_data[7];
            end
            if (w_rise) begin
                r_sclk     <= 1'b1;
                r_rx_shift <= {r_rx_shift[6:0], mcu_miso};
            end
            if (w_fall) begin
                r_sclk <= 1'b0;
                if (w_last_fall) begin
                    r_rx_data  <= r_rx_shift;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_mosi     <= r_tx_shift[6];
                    r_tx_shift <= {r_tx_shift[5:0], 1'b0};
                end
            end
            if ((r_state == S_HOLD) && w_half_done) begin
                r_csn  <= 1'b1;
                r_mosi <= 1'b0;
            end
        end
    end

`ifdef MCU_SPI_HOST_IRQ_EN
    logic [1:0] r_intn_sync;

    // Two-flop synchroniser for the asynchronous interrupt line
    always_ff @(posedge clk) begin
        if (reset) begin
            r_intn_sync <= 2'b11;
        end else begin
            r_intn_sync <= {r_intn_sync[0], mcu_intn};
        end
    end

    assign irq = ~r_intn_sync[1];
`else
    logic w_unused_intn;
    assign w_unused_intn = mcu_intn;
    assign irq           = 1'b0;
`endif

    assign tx_ready = w_tx_ready;
    assign busy     = (r_state != S_IDLE);
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign mcu_sclk = r_sclk;
    assign mcu_csn  = r_csn;
    assign mcu_mosi = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_mcu_spi_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcu_spi_host
// Purpose  : Scoreboard bench for mcu_spi_host. Two instances are used:
//            CLK_DIV=2 (index 0) and CLK_DIV=1 (index 1), exercised one at a
//            time. A behavioural SPI slave returns queued bytes and records
//            MOSI. Expected bytes and event cycles come from the link's
//            frame/byte timing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcu_spi_host;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_last;
    logic [1:0] tx_valid;
    logic [1:0] frame_end;
    logic [1:0] tx_ready, rx_valid, busy, irq, sclk, csn, mosi;
    logic [7:0] rx_data [2];
    logic       miso = 1'b0;
    logic       intn;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mcu_spi_host #(.CLK_DIV((g == 0) ? 2 : 1)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .tx_data   (tx_data),
            .tx_valid  (tx_valid[g]),
            .tx_last   (tx_last),
            .tx_ready  (tx_ready[g]),
            .frame_end (frame_end[g]),
            .rx_data   (rx_data[g]),
            .rx_valid  (rx_valid[g]),
            .busy      (busy[g]),
            .irq       (irq[g]),
            .mcu_sclk  (sclk[g]),
            .mcu_csn   (csn[g]),
            .mcu_mosi  (mosi[g]),
            .mcu_miso  (miso),
            .mcu_intn  (intn)
        );
    end

`ifdef MCU_SPI_HOST_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int sel      = 0;     // active instance
    int dv       = 2;     // its CLK_DIV
    int frame_bytes = 0;

    // scoreboard queues
    int         exp_rise  [$];
    int         exp_rxv   [$];
    int         exp_csn   [$];
    int         exp_edges [$];
    logic [7:0] exp_tx    [$];
    logic [7:0] exp_rx    [$];
    logic [7:0] slv_q     [$];

    // monitor / slave state
    int         edges     = 0;
    int         slv_idx   = 0;
    int         ready_due = -100;
    int         rise_cyc  = -1000;
    logic [7:0] slv_cap   = 8'h00;
    logic [7:0] cur       = 8'h00;
    logic       sclk_p    = 1'b0;
    logic       csn_p     = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor + SPI slave: samples away from the active edge
    always @(negedge clk) begin
        if (reset) begin
            exp_rise.delete(); exp_rxv.delete(); exp_csn.delete(); exp_edges.delete();
            exp_tx.delete(); exp_rx.delete(); slv_q.delete();
            slv_idx   = 0;
            edges     = 0;
            ready_due = -100;
        end else begin
            if (csn[sel]) begin
                check("mosi_low_when_deselected", mosi[sel], 0);
                check("sclk_low_when_deselected", sclk[sel], 0);
            end
            if (!sclk_p && sclk[sel]) begin
                if (slv_idx == 0) begin
                    check("rise_expected", exp_rise.size() > 0, 1);
                    if (exp_rise.size() > 0) check("first_rise_cycle", cyc, exp_rise.pop_front());
                end
                slv_cap = {slv_cap[6:0], mosi[sel]};
                slv_idx++;
                edges++;
                if (slv_idx == 8) begin
                    slv_idx = 0;
                    check("mosi_byte_expected", exp_tx.size() > 0, 1);
                    if (exp_tx.size() > 0) check("mosi_byte", slv_cap, exp_tx.pop_front());
                    if (slv_q.size() > 0) void'(slv_q.pop_front());
                end
            end
            if (rx_valid[sel]) begin
                check("rx_expected", exp_rx.size() > 0, 1);
                if (exp_rx.size() > 0) begin
                    check("rx_data", rx_data[sel], exp_rx.pop_front());
                    check("rx_valid_cycle", cyc, exp_rxv.pop_front());
                end
            end
            if (!csn[sel] && csn_p) begin
                check("csn_high_min", (cyc - rise_cyc) >= dv, 1);
            end
            if (csn[sel] && !csn_p) begin
                check("csn_rise_expected", exp_csn.size() > 0, 1);
                if (exp_csn.size() > 0) begin
                    check("csn_rise_cycle", cyc, exp_csn.pop_front());
                    check("frame_rising_edges", edges, exp_edges.pop_front());
                end
                edges     = 0;
                rise_cyc  = cyc;
                ready_due = cyc + dv;
            end
            if (cyc == ready_due - 1) check("desel_ready_low", tx_ready[sel], 0);
            if (cyc == ready_due) begin
                check("ready_return", tx_ready[sel], 1);
                check("busy_idle", busy[sel], 0);
            end
            if (slv_q.size() > 0) begin
                cur  = slv_q[0];
                miso = cur[3'(7 - slv_idx)];
            end else begin
                miso = 1'b0;
            end
        end
        sclk_p = sclk[sel];
        csn_p  = csn[sel];
    end

    // Offer a byte; push expectations for the cycle it is accepted
    task automatic send(input logic [7:0] data, input logic last, input logic [7:0] resp);
        int n = 0;
        tx_data = data;
        tx_last = last;
        tx_valid[sel] = 1'b1;
        @(negedge clk);
        while (!tx_ready[sel] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", tx_ready[sel], 1);
        if (tx_ready[sel]) begin
            slv_q.push_back(resp);
            exp_tx.push_back(data);
            exp_rx.push_back(resp);
            exp_rise.push_back(cyc + 1 + dv);
            exp_rxv.push_back(cyc + 1 + 16 * dv);
            frame_bytes++;
            if (last) begin
                exp_csn.push_back(cyc + 1 + 17 * dv);
                exp_edges.push_back(8 * frame_bytes);
                frame_bytes = 0;
            end
        end
        @(posedge clk); #1;
        tx_valid[sel] = 1'b0;
    endtask

    // Close an open frame from WAIT, optionally with a competing tx_valid
    task automatic close_fe(input int idle, input logic with_valid);
        int n = 0;
        while (exp_rx.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("wait_reached", exp_rx.size(), 0);
        repeat (idle) @(posedge clk);
        @(posedge clk); #1;
        frame_end[sel] = 1'b1;
        tx_valid[sel]  = with_valid;
        tx_data        = 8'h77;
        tx_last        = 1'b0;
        @(negedge clk);
        check("busy_in_wait", busy[sel], 1);
        check("ready_blocked_by_frame_end", tx_ready[sel], 0);
        exp_csn.push_back(cyc + 1 + dv);
        exp_edges.push_back(8 * frame_bytes);
        frame_bytes = 0;
        @(posedge clk); #1;
        frame_end[sel] = 1'b0;
        tx_valid[sel]  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_csn.size() != 0 || !tx_ready[sel] || busy[sel]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("idle_in_time", n < 2000, 1);
        check("idle_busy_low", busy[sel], 0);
        @(posedge clk); #1;
    endtask

    task automatic rand_frames(input int count);
        for (int f = 0; f < count; f++) begin
            int   nb     = $urandom_range(1, 4);
            logic use_fe = ($urandom_range(0, 2) == 0);
            for (int b = 0; b < nb; b++) begin
                logic lst = !use_fe && (b == nb - 1);
                send(8'($urandom), lst, 8'($urandom));
                if (!lst && $urandom_range(0, 3) == 0) begin
                    // state is SETUP here: frame_end must be ignored
                    frame_end[sel] = 1'b1;
                    @(posedge clk); #1;
                    frame_end[sel] = 1'b0;
                end
                repeat ($urandom_range(0, 40)) @(posedge clk);
                #1;
            end
            if (use_fe) close_fe($urandom_range(0, 5), 1'($urandom_range(0, 1)));
            wait_idle();
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_test();
        int n = 0;
        send(8'hC3, 1'b1, 8'h96);
        while (edges < 3 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("third_rise_seen", edges, 3);
        #1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midrst_csn", csn[sel], 1);
        check("midrst_sclk", sclk[sel], 0);
        check("midrst_mosi", mosi[sel], 0);
        check("midrst_busy", busy[sel], 0);
        check("midrst_rx_valid", rx_valid[sel], 0);
        check("midrst_ready_low", tx_ready[sel], 0);
        @(posedge clk); #1;
        reset = 1'b0;
        frame_bytes = 0;
        repeat (60) @(posedge clk);
        #1;
    endtask

    task automatic irq_phase(input logic level);
        @(posedge clk); #1;
        intn = level;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check("irq_latency", irq[d], IRQ_ON & ((k == 2) ? ~level : level));
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        tx_data   = 8'h00;
        tx_last   = 1'b0;
        tx_valid  = 2'b00;
        frame_end = 2'b00;
        intn      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_csn", csn[d], 1);
            check("rst_sclk", sclk[d], 0);
            check("rst_mosi", mosi[d], 0);
            check("rst_rx_valid", rx_valid[d], 0);
            check("rst_rx_data", rx_data[d], 0);
            check("rst_busy", busy[d], 0);
            check("rst_irq", irq[d], 0);
            check("rst_tx_ready", tx_ready[d], 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // CLK_DIV = 2
        sel = 0;
        dv  = 2;
        send(8'hA5, 1'b1, 8'h3C);
        wait_idle();
        send(8'h01, 1'b0, 8'($urandom));
        send(8'h02, 1'b0, 8'($urandom));
        send(8'h03, 1'b1, 8'($urandom));
        wait_idle();
        send(8'h5A, 1'b0, 8'hE1);
        close_fe(50, 1'b1);
        wait_idle();
        rand_frames(20);
        reset_test();
        rand_frames(5);

        // CLK_DIV = 1
        sel = 1;
        dv  = 1;
        for (int k = 0; k < 8; k++) begin
            send((k % 2 == 0) ? 8'hFF : 8'h00, 1'b1, 8'($urandom));
            wait_idle();
        end
        rand_frames(20);

        irq_phase(1'b0);
        irq_phase(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
